// File: rtl/zet_alu_pkg.sv
// ----------------------------------------------------------------------------
// zet_alu_pkg
// Shared definitions for the Zet ALU writeback stage:
//   - architectural FLAGS bit positions (CF, PF, AF, ZF, SF, OF)
//   - bit order of the 6-bit flag/fmask vectors: {OF,SF,ZF,AF,PF,CF}
//   - mask of reserved FLAGS bits (1, 3, 5, 12-15)
//   - the writeback buffer entry layout
//   - helpers to scatter a 6-bit flag vector into FLAGS positions and to
//     compute the x86 parity flag
// ----------------------------------------------------------------------------
package zet_alu_pkg;

  // Architectural FLAGS bit positions
  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int OF_BIT = 11;

  // Positions inside the compact 6-bit vectors {OF,SF,ZF,AF,PF,CF}
  localparam int FM_CF = 0;
  localparam int FM_PF = 1;
  localparam int FM_AF = 2;
  localparam int FM_ZF = 3;
  localparam int FM_SF = 4;
  localparam int FM_OF = 5;

  // Reserved FLAGS bits: always sourced from the reset value
  localparam logic [15:0] RSV_MASK = 16'hF02A;

  // One buffered ALU result
  typedef struct packed {
    logic [15:0] res;
    logic [5:0]  flags6;
    logic [5:0]  fmask;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // Place a compact 6-bit flag vector at its architectural FLAGS positions
  function automatic logic [15:0] expand_flags(input logic [5:0] f6);
    logic [15:0] v;
    v         = 16'h0000;
    v[CF_BIT] = f6[FM_CF];
    v[PF_BIT] = f6[FM_PF];
    v[AF_BIT] = f6[FM_AF];
    v[ZF_BIT] = f6[FM_ZF];
    v[SF_BIT] = f6[FM_SF];
    v[OF_BIT] = f6[FM_OF];
    return v;
  endfunction

  // x86 PF: set when the low byte has an even number of ones
  function automatic logic parity_even(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/zet_alu_wb_fifo.sv
// ----------------------------------------------------------------------------
// zet_alu_wb_fifo
// Generic 2-entry skid FIFO with valid/ready on both sides. Entry 0 is
// always the head, so the output data comes straight from a register.
// in_ready and out_valid depend only on the registered occupancy count.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear: empties the FIFO, same-cycle push and
//                pop are ignored
//   in_valid     write request          in_ready   FIFO has space
//   din [W]      write data
//   out_valid    head entry valid       out_ready  consumer takes head
//   dout [W]     head entry data (zero after reset)
// ----------------------------------------------------------------------------
module zet_alu_wb_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);

  logic [1:0]   count_r;
  logic [W-1:0] e0_r;
  logic [W-1:0] e1_r;

  logic [1:0]   count_s;
  logic [W-1:0] e0_s;
  logic [W-1:0] e1_s;
  logic         push_s;
  logic         pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign dout      = e0_r;

  assign push_s = in_valid  && in_ready  && !clr;
  assign pop_s  = out_valid && out_ready && !clr;

  // Next-state computation for occupancy and the two entry slots
  always_comb begin
    count_s = count_r;
    e0_s    = e0_r;
    e1_s    = e1_r;
    if (clr) begin
      count_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          count_s = count_r + 2'd1;
          if (count_r == 2'd0) begin
            e0_s = din;
          end else begin
            e1_s = din;
          end
        end
        2'b01: begin
          count_s = count_r - 2'd1;
          e0_s    = e1_r;
        end
        2'b11: begin
          // Only reachable with one entry held: the new entry becomes head
          count_s = count_r;
          if (count_r == 2'd1) begin
            e0_s = din;
          end else begin
            e0_s = e1_r;
            e1_s = din;
          end
        end
        default: begin
          count_s = count_r;
        end
      endcase
    end
  end

  // Occupancy and entry storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 2'd0;
      e0_r    <= {W{1'b0}};
      e1_r    <= {W{1'b0}};
    end else begin
      count_r <= count_s;
      e0_r    <= e0_s;
      e1_r    <= e1_s;
    end
  end

endmodule

// File: rtl/zet_alu_wb.sv
// ----------------------------------------------------------------------------
// zet_alu_wb
// ALU writeback stage of the Zet core. Derives ZF/SF/PF from the ALU result
// (byte or word width), takes CF/OF/AF from the ALU sub-units, and queues
// {result, flags, fmask} in a 2-entry skid FIFO. The architectural FLAGS
// register is updated from the head entry when it retires downstream, or
// loaded wholesale by POPF/IRET (load wins over a same-cycle commit).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_res[16]          ALU result
//   in_cfo/ofo/afo      carry, overflow, auxiliary carry from the ALU
//   in_word             1 = word op, 0 = byte op
//   in_fmask[6]         flags this op writes, {OF,SF,ZF,AF,PF,CF}
//   out_valid/out_ready downstream handshake
//   out_res[16]         head result
//   out_flags[16]       head flags merged over the current FLAGS
//   flags[16]           architectural FLAGS
//   ld_flags, ld_val    FLAGS load strobe and value
//   flush               synchronous buffer clear
// ----------------------------------------------------------------------------
module zet_alu_wb
  import zet_alu_pkg::*;
#(
  parameter logic [15:0] FLAGS_RST = 16'h0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_res,
  input  logic        in_cfo,
  input  logic        in_ofo,
  input  logic        in_afo,
  input  logic        in_word,
  input  logic [5:0]  in_fmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic [15:0] out_flags,
  output logic [15:0] flags,
  input  logic        ld_flags,
  input  logic [15:0] ld_val,
  input  logic        flush
);

  wb_entry_t   in_entry_s;
  wb_entry_t   head_s;
  logic        zf_s;
  logic        sf_s;
  logic [5:0]  flags6_s;
  logic [15:0] upd_mask_s;
  logic [15:0] head_val_s;
  logic        commit_s;
  logic [15:0] flags_r;
  logic [15:0] flags_s;

  // Status flag derivation from the incoming ALU result
  always_comb begin
    zf_s = 1'b0;
    sf_s = 1'b0;
    if (in_word) begin
      zf_s = (in_res == 16'h0000);
      sf_s = in_res[15];
    end else begin
      zf_s = (in_res[7:0] == 8'h00);
      sf_s = in_res[7];
    end
  end

  // Pack derived flags in {OF,SF,ZF,AF,PF,CF} order and build the entry
  always_comb begin
    flags6_s        = 6'b000000;
    flags6_s[FM_CF] = in_cfo;
    flags6_s[FM_PF] = parity_even(in_res[7:0]);
    flags6_s[FM_AF] = in_afo;
    flags6_s[FM_ZF] = zf_s;
    flags6_s[FM_SF] = sf_s;
    flags6_s[FM_OF] = in_ofo;
    in_entry_s.res    = in_res;
    in_entry_s.flags6 = flags6_s;
    in_entry_s.fmask  = in_fmask;
  end

  zet_alu_wb_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (in_entry_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (head_s)
  );

  // A retire during flush is discarded, so it must not touch FLAGS
  assign commit_s   = out_valid && out_ready && !flush;
  assign upd_mask_s = expand_flags(head_s.fmask);
  assign head_val_s = expand_flags(head_s.flags6);

  assign out_res   = head_s.res;
  assign out_flags = (flags_r & ~upd_mask_s) | (head_val_s & upd_mask_s);
  assign flags     = flags_r;

  // FLAGS next value: load beats commit, reserved bits always from reset value
  always_comb begin
    flags_s = flags_r;
    if (ld_flags) begin
      flags_s = (ld_val & ~RSV_MASK) | (FLAGS_RST & RSV_MASK);
    end else if (commit_s) begin
      flags_s = out_flags;
    end else begin
      flags_s = flags_r;
    end
  end

  // Architectural FLAGS register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= FLAGS_RST;
    end else begin
      flags_r <= flags_s;
    end
  end

endmodule

// File: tb/tb_zet_alu_wb.sv
// ----------------------------------------------------------------------------
// tb_zet_alu_wb
// Directed vectors with hand-computed results. The driver pushes the
// expected {out_res, out_flags} of every accepted entry into a queue; an
// independent monitor pops and compares whenever an entry retires.
// ----------------------------------------------------------------------------
module tb_zet_alu_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_res;
  logic        in_cfo;
  logic        in_ofo;
  logic        in_afo;
  logic        in_word;
  logic [5:0]  in_fmask;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic [15:0] out_flags;
  logic [15:0] flags;
  logic        ld_flags;
  logic [15:0] ld_val;
  logic        flush;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] oflags;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   nvec;
  int   nerr;

  zet_alu_wb #(.FLAGS_RST(16'h0002)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_cfo    (in_cfo),
    .in_ofo    (in_ofo),
    .in_afo    (in_afo),
    .in_word   (in_word),
    .in_fmask  (in_fmask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags),
    .flags     (flags),
    .ld_flags  (ld_flags),
    .ld_val    (ld_val),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one ALU result, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [15:0] res, input logic word, input logic cfo,
                      input logic ofo, input logic afo, input logic [5:0] fm,
                      input logic [15:0] exp_oflags);
    int n;
    in_res   = res;
    in_word  = word;
    in_cfo   = cfo;
    in_ofo   = ofo;
    in_afo   = afo;
    in_fmask = fm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", {15'h0000, in_ready}, 16'h0001);
    exp_q.push_back('{res: res, oflags: exp_oflags});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 16'(exp_q.size()), 16'h0000);
  endtask

  // Monitor: compare each retiring entry against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_out: got res %h, expected no entry", out_res);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_res", out_res, mon_e.res);
          check("out_flags", out_flags, mon_e.oflags);
        end
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0;
    nerr = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_res = 16'h0000;
    in_cfo = 1'b0;
    in_ofo = 1'b0;
    in_afo = 1'b0;
    in_word = 1'b0;
    in_fmask = 6'b000000;
    out_ready = 1'b0;
    ld_flags = 1'b0;
    ld_val = 16'h0000;
    flush = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {15'h0000, out_valid}, 16'h0000);
    check("rst_in_ready", {15'h0000, in_ready}, 16'h0001);
    check("rst_flags", flags, 16'h0002);
    check("rst_out_res", out_res, 16'h0000);
    check("rst_out_flags", out_flags, 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte result 0x00FF, all flags written
    out_ready = 1'b1;
    send(16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 16'h0086);
    @(posedge clk);
    #1;
    check("byte_flags", flags, 16'h0086);

    // Set CF only
    send(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000001, 16'h0087);
    @(posedge clk);
    #1;
    check("cf_set_flags", flags, 16'h0087);

    // Word zero, OF/SF/ZF/PF written, CF preserved
    send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111010, 16'h0047);
    @(posedge clk);
    #1;
    check("word_zero_flags", flags, 16'h0047);

    // Backpressure: two entries fill the buffer, third waits
    out_ready = 1'b0;
    send(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 16'h0047);
    send(16'h5678, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 16'h0047);
    check("bp_in_ready", {15'h0000, in_ready}, 16'h0000);
    check("bp_head", out_res, 16'h1234);
    fork
      send(16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000, 16'h00C7);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    #1;
    check("bp_flags", flags, 16'h00C7);
    check("bp_empty", {15'h0000, out_valid}, 16'h0000);

    // Load and commit in the same cycle: load wins, entry retires
    out_ready = 1'b0;
    send(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 16'h0087);
    ld_val = 16'hFFFF;
    ld_flags = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    ld_flags = 1'b0;
    check("ld_flags", flags, 16'h0FD7);
    check("ld_retired", {15'h0000, out_valid}, 16'h0000);

    // Flush with a pending commit and a same-cycle push
    out_ready = 1'b0;
    send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111111, 16'h0746);
    in_res = 16'h5555;
    in_word = 1'b1;
    in_fmask = 6'b111111;
    in_valid = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {15'h0000, out_valid}, 16'h0000);
    check("flush_flags", flags, 16'h0FD7);
    check("flush_in_ready", {15'h0000, in_ready}, 16'h0001);
    @(posedge clk);
    #1;
    check("flush_drop", {15'h0000, out_valid}, 16'h0000);

    // Asynchronous reset with the buffer full
    out_ready = 1'b0;
    send(16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111111, 16'h0000);
    send(16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111111, 16'h0000);
    check("full_in_ready", {15'h0000, in_ready}, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {15'h0000, out_valid}, 16'h0000);
    check("arst_in_ready", {15'h0000, in_ready}, 16'h0001);
    check("arst_flags", flags, 16'h0002);
    check("arst_out_res", out_res, 16'h0000);
    check("arst_out_flags", out_flags, 16'h0002);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Operation after reset
    out_ready = 1'b1;
    send(16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 16'h0086);
    wait_drain();
    @(posedge clk);
    #1;
    check("post_rst_flags", flags, 16'h0086);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
